// File: rtl/data_cache_pkg.sv
// Shared constants, FSM state type and lane helper for the data cache.
package data_cache_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned WORDS          = 4;
    localparam int unsigned WORD_SEL_W     = 2;
    localparam int unsigned BE_W           = 4;
    localparam int unsigned DC_OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        DC_IDLE   = 2'd0,
        DC_REFILL = 2'd1,
        DC_WRITE  = 2'd2
    } dcState_t;

    // One-hot byte enable for a little-endian byte lane (lane 0 = bits [7:0]).
    function automatic logic [BE_W-1:0] byteLaneBe(input logic [1:0] lane);
        return BE_W'(4'b0001 << lane);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage: async read at one index, byte-enabled word write.
module dcache_array
    import data_cache_pkg::*;
#(
    parameter int unsigned LINES = 16,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned TAG_W = 24
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [IDX_W-1:0]                 rdIdx,
    output logic                             rdValid,
    output logic [TAG_W-1:0]                 rdTag,
    output logic [WORDS-1:0][DATA_W-1:0]     rdLine,
    input  logic                             wrEn,
    input  logic [IDX_W-1:0]                 wrIdx,
    input  logic [WORD_SEL_W-1:0]            wrWord,
    input  logic [BE_W-1:0]                  wrBe,
    input  logic [DATA_W-1:0]                wrData,
    input  logic                             invalidate,
    input  logic                             setTag,
    input  logic [TAG_W-1:0]                 wrTag
);

    logic [LINES-1:0]                validQ;
    logic [TAG_W-1:0]                tagQ  [LINES];
    logic [WORDS-1:0][DATA_W-1:0]    dataQ [LINES];

    // Asynchronous lookup at the requested index.
    assign rdValid = validQ[rdIdx];
    assign rdTag   = tagQ[rdIdx];
    assign rdLine  = dataQ[rdIdx];

    // Valid bits: cleared on reset, dropped at the start of a refill, set when it completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            validQ <= '0;
        end else if (invalidate) begin
            validQ[wrIdx] <= 1'b0;
        end else if (setTag) begin
            validQ[wrIdx] <= 1'b1;
        end
    end

    // Tag written together with the final refill beat.
    always_ff @(posedge clk) begin
        if (setTag) begin
            tagQ[wrIdx] <= wrTag;
        end
    end

    // Byte-enabled word write.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (wrBe[b]) begin
                    dataQ[wrIdx][wrWord][8*b +: 8] <= wrData[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the memory stage.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int unsigned LINES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic        MemWriteSBM,
    input  logic [31:0] AddrM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_W - DC_OFFSET_BITS - IDX_W;

    dcState_t state, nextState;
    logic [WORD_SEL_W-1:0] beat;

    logic isStore, isWordStore, isLoad, ackQual, hit;
    logic [IDX_W-1:0] lookupIdx;
    logic [TAG_W-1:0] lookupTag;

    logic                          rdValid;
    logic [TAG_W-1:0]              rdTag;
    logic [WORDS-1:0][DATA_W-1:0]  rdLine;

    logic                  wrEn, invalidate, setTag;
    logic [IDX_W-1:0]      wrIdx;
    logic [WORD_SEL_W-1:0] wrWord;
    logic [BE_W-1:0]       wrBe;
    logic [DATA_W-1:0]     wrData;
    logic [TAG_W-1:0]      wrTag;

    // Request decode: stores win over loads; both store kinds together act as a word store.
    assign isStore     = MemWriteM | MemWriteSBM;
    assign isWordStore = MemWriteM;
    assign isLoad      = MemReadM & ~isStore;
    assign ackQual     = mem_ack & mem_req;

    // In IDLE look up the pipeline address; while busy, the held backing address.
    assign lookupIdx = (state == DC_IDLE) ? AddrM[DC_OFFSET_BITS +: IDX_W]
                                          : mem_addr[DC_OFFSET_BITS +: IDX_W];
    assign lookupTag = (state == DC_IDLE) ? AddrM[ADDR_W-1 -: TAG_W]
                                          : mem_addr[ADDR_W-1 -: TAG_W];
    assign hit       = rdValid && (rdTag == lookupTag);

    dcache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) uArray (
        .clk        (clk),
        .reset      (reset),
        .rdIdx      (lookupIdx),
        .rdValid    (rdValid),
        .rdTag      (rdTag),
        .rdLine     (rdLine),
        .wrEn       (wrEn),
        .wrIdx      (wrIdx),
        .wrWord     (wrWord),
        .wrBe       (wrBe),
        .wrData     (wrData),
        .invalidate (invalidate),
        .setTag     (setTag),
        .wrTag      (wrTag)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DC_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state, pipeline stall and zero-latency load data.
    always_comb begin
        nextState = state;
        StallM    = 1'b0;
        ReadDataM = '0;
        case (state)
            DC_IDLE: begin
                if (isStore) begin
                    StallM    = 1'b1;
                    nextState = DC_WRITE;
                end else if (isLoad) begin
                    if (hit) begin
                        ReadDataM = rdLine[AddrM[3:2]];
                    end else begin
                        StallM    = 1'b1;
                        nextState = DC_REFILL;
                    end
                end
            end
            DC_REFILL: begin
                StallM = 1'b1;
                if (ackQual && beat == 2'd3) begin
                    nextState = DC_IDLE;
                end
            end
            DC_WRITE: begin
                StallM = ~ackQual;
                if (ackQual) begin
                    nextState = DC_IDLE;
                end
            end
            default: nextState = DC_IDLE;
        endcase
    end

    // Array writes: refill beats from memory, or a write-through hit update.
    always_comb begin
        wrEn       = 1'b0;
        invalidate = 1'b0;
        setTag     = 1'b0;
        wrIdx      = mem_addr[DC_OFFSET_BITS +: IDX_W];
        wrTag      = mem_addr[ADDR_W-1 -: TAG_W];
        wrWord     = beat;
        wrBe       = '1;
        wrData     = mem_rdata;
        case (state)
            DC_REFILL: begin
                if (ackQual) begin
                    wrEn       = 1'b1;
                    invalidate = (beat == 2'd0);
                    setTag     = (beat == 2'd3);
                end
            end
            DC_WRITE: begin
                if (ackQual && hit) begin
                    wrEn   = 1'b1;
                    wrWord = mem_addr[3:2];
                    wrBe   = mem_be;
                    wrData = mem_wdata;
                end
            end
            default: ;
        endcase
    end

    // Backing-memory request registers and refill beat counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            beat      <= '0;
        end else begin
            case (state)
                DC_IDLE: begin
                    if (isStore) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {AddrM[31:2], 2'b00};
                        mem_be    <= isWordStore ? 4'b1111 : byteLaneBe(AddrM[1:0]);
                        mem_wdata <= isWordStore ? WriteDataM : {4{WriteDataM[7:0]}};
                    end else if (isLoad && !hit) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= {AddrM[31:4], 4'b0000};
                        mem_be    <= '0;
                        mem_wdata <= '0;
                        beat      <= '0;
                    end
                end
                DC_REFILL: begin
                    if (ackQual) begin
                        beat     <= beat + 2'd1;
                        mem_addr <= mem_addr + 32'd4;
                        if (beat == 2'd3) begin
                            mem_req <= 1'b0;
                        end
                    end
                end
                DC_WRITE: begin
                    if (ackQual) begin
                        mem_req <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a 2-cycle-latency backing memory model.
module tb_data_cache;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM, MemWriteSBM;
    logic [31:0] AddrM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_cache dut (
        .clk         (clk),
        .reset       (reset),
        .MemReadM    (MemReadM),
        .MemWriteM   (MemWriteM),
        .MemWriteSBM (MemWriteSBM),
        .AddrM       (AddrM),
        .WriteDataM  (WriteDataM),
        .ReadDataM   (ReadDataM),
        .StallM      (StallM),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Backing memory: unwritten words read as 0xC0DE_<addr[15:0]>.
    logic [31:0] backing [int unsigned];

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (backing.exists(a)) return backing[a];
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
    } memLog_t;
    memLog_t memLog[$];

    logic        respEn   = 1'b1;
    logic        respAck  = 1'b0;
    logic [31:0] respData = '0;
    logic        manAck   = 1'b0;
    logic [31:0] manData  = '0;
    int          respCnt  = 0;
    logic [31:0] wordTmp;

    assign mem_ack   = respEn ? respAck  : manAck;
    assign mem_rdata = respEn ? respData : manData;

    // Responder: ack every request two cycles after it is seen, one beat at a time.
    always @(posedge clk) begin
        #1;
        if (respAck) begin
            respAck = 1'b0;
            respCnt = 0;
        end else if (respEn && mem_req) begin
            respCnt++;
            if (respCnt == 2) begin
                respAck = 1'b1;
                memLog.push_back('{mem_we, mem_addr, mem_be});
                if (mem_we) begin
                    wordTmp = memRead(mem_addr);
                    for (int b = 0; b < 4; b++) begin
                        if (mem_be[b]) wordTmp[8*b +: 8] = mem_wdata[8*b +: 8];
                    end
                    backing[mem_addr] = wordTmp;
                end else begin
                    respData = memRead(mem_addr);
                end
            end
        end else begin
            respCnt = 0;
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic sb,
                         input logic [31:0] a, input logic [31:0] d);
        MemReadM    = rd;
        MemWriteM   = wr;
        MemWriteSBM = sb;
        AddrM       = a;
        WriteDataM  = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts stalled cycles; returns at the first negedge with StallM low.
    task automatic waitFree(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!StallM) return;
            n++;
            step();
        end
        check("stall_timeout", 32'd1, 32'd0);
    endtask

    // Issue a load at posedge+1 and check stall length and returned data.
    task automatic load(input string tag, input logic [31:0] a,
                        input int expStall, input logic [31:0] expData);
        int n;
        drive(1'b1, 1'b0, 1'b0, a, 32'h0);
        waitFree(n);
        check({tag, "_stall"}, 32'(n), 32'(expStall));
        check({tag, "_data"}, ReadDataM, expData);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();
        @(negedge clk);
        check("rst_stall", 32'(StallM), 32'd0);
        check("rst_rdata", ReadDataM, 32'h0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_be", 32'(mem_be), 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("idle_stall", 32'(StallM), 32'd0);
        check("idle_rdata", ReadDataM, 32'h0);

        // Cold miss: four beats, 12 stalled cycles, then the held load hits.
        step();
        memLog.delete();
        load("lw100_miss", 32'h100, 12, 32'hC0DE_0100);
        check("refill_beats", 32'(memLog.size()), 32'd4);
        if (memLog.size() == 4) begin
            check("beat0_addr", memLog[0].addr, 32'h100);
            check("beat1_addr", memLog[1].addr, 32'h104);
            check("beat2_addr", memLog[2].addr, 32'h108);
            check("beat3_addr", memLog[3].addr, 32'h10C);
            check("beat3_we", 32'(memLog[3].we), 32'd0);
        end

        // Hit: same-cycle data, no backing request.
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h104, 32'h0);
        @(negedge clk);
        check("lw104_hit_stall", 32'(StallM), 32'd0);
        check("lw104_hit_data", ReadDataM, 32'hC0DE_0104);
        check("lw104_hit_req", 32'(mem_req), 32'd0);

        // Byte store to lane 1 of a cached word.
        step();
        drive(1'b0, 1'b0, 1'b1, 32'h105, 32'h0000_00AB);
        @(negedge clk);
        check("sb_stall", 32'(StallM), 32'd1);
        step();
        @(negedge clk);
        check("sb_req", 32'(mem_req), 32'd1);
        check("sb_we", 32'(mem_we), 32'd1);
        check("sb_be", 32'(mem_be), 32'h2);
        check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        check("sb_addr", mem_addr, 32'h104);
        waitFree(n);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h104, 32'h0);
        @(negedge clk);
        check("lw104_after_sb_stall", 32'(StallM), 32'd0);
        check("lw104_after_sb_data", ReadDataM, 32'hC0DE_AB04);

        // Store miss is write-through only; the following load still misses.
        step();
        memLog.delete();
        drive(1'b0, 1'b1, 1'b0, 32'h900, 32'h1122_3344);
        waitFree(n);
        check("sw900_stall", 32'(n), 32'd2);
        check("sw900_log", 32'(memLog.size()), 32'd1);
        if (memLog.size() == 1) begin
            check("sw900_we", 32'(memLog[0].we), 32'd1);
            check("sw900_addr", memLog[0].addr, 32'h900);
            check("sw900_be", 32'(memLog[0].be), 32'hF);
        end
        step();
        load("lw900_noalloc", 32'h900, 12, 32'h1122_3344);

        // Conflicts in index 0.
        step();
        load("lw100_evicted", 32'h100, 12, 32'hC0DE_0100);
        step();
        load("lw200_conflict", 32'h200, 12, 32'hC0DE_0200);
        step();
        load("lw104_evicted", 32'h104, 12, 32'hC0DE_AB04);

        // Reset in the middle of a refill, then a late ack.
        step();
        respEn = 1'b0;
        manAck = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h300, 32'h0);
        step();
        manAck = 1'b1; manData = 32'hDEAD_0000;
        step();
        manAck = 1'b0;
        step();
        manAck = 1'b1; manData = 32'hDEAD_0004;
        step();
        manAck = 1'b0;
        @(negedge clk);
        check("beat2_req", 32'(mem_req), 32'd1);
        check("beat2_addr_held", mem_addr, 32'h308);
        check("beat2_stall", 32'(StallM), 32'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        manAck = 1'b1; manData = 32'hDEAD_0008;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("abort_req", 32'(mem_req), 32'd0);
        check("abort_stall", 32'(StallM), 32'd0);
        step();
        manAck = 1'b0;
        @(negedge clk);
        check("late_ack_req", 32'(mem_req), 32'd0);
        check("late_ack_stall", 32'(StallM), 32'd0);
        respEn = 1'b1;
        step();
        load("lw100_after_rst", 32'h100, 12, 32'hC0DE_0100);
        step();
        load("lw300_after_rst", 32'h300, 12, 32'hC0DE_0300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
